// File: rtl/ccd_sequencer.sv
// CCD clock sequencer: pre-exposure flush, exposure, binned V/H readout.
// Every output is registered from the next-state values of the FSM.
module ccd_sequencer #(
    parameter int VP_MAX  = 16,
    parameter int HP_MAX  = 8,
    parameter int DIM_W   = 16,
    parameter int DWELL_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DIM_W-1:0]             width,
    input  logic [DIM_W-1:0]             height,
    input  logic [DIM_W-1:0]             hbin,
    input  logic [DIM_W-1:0]             vbin,
    input  logic [$clog2(VP_MAX+1)-1:0]  num_vertical_phases,
    input  logic [$clog2(HP_MAX+1)-1:0]  num_horizontal_phases,
    input  logic [DWELL_W-1:0]           v_dwell,
    input  logic [DWELL_W-1:0]           h_dwell,
    input  logic                         flush_en,
    input  logic                         start_exposure,
    input  logic                         complete_exposure,
    input  logic                         start_read,
    input  logic                         abort,
    output logic [VP_MAX-1:0]            vertical_phases,
    output logic [HP_MAX-1:0]            horizontal_phases,
    output logic                         read_sample,
    output logic                         read_completed,
    output logic                         busy,
    output logic                         exposing,
    output logic                         cfg_error
);
    localparam int NVW  = $clog2(VP_MAX + 1);
    localparam int NHW  = $clog2(HP_MAX + 1);
    localparam int PMAX = (VP_MAX > HP_MAX) ? VP_MAX : HP_MAX;
    localparam int SW   = (PMAX > 2) ? $clog2(PMAX) : 1;

    typedef enum logic [3:0] {
        IDLE, FLUSH_V, FLUSH_H, EXPOSE, READY,
        VSHIFT, HSHIFT, SAMPLE, DONE
    } state_t;

    state_t state_q, state_d;

    logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]   hb_q, hb_d, vb_q, vb_d;
    logic [NVW-1:0]     nv_q, nv_d;
    logic [NHW-1:0]     nh_q, nh_d;
    logic [DWELL_W-1:0] dv_q, dv_d, dh_q, dh_d;

    logic [SW-1:0]      step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DIM_W-1:0]   cnt_q, cnt_d;
    logic [DIM_W-1:0]   px_q, px_d;
    logic [DIM_W-1:0]   bin_q, bin_d;
    logic               err_d;

    logic [VP_MAX-1:0]  vph_q, vph_d;
    logic [HP_MAX-1:0]  hph_q, hph_d;
    logic               rs_q, rs_d, rc_q, rc_d;
    logic               busy_q, busy_d, exp_q, exp_d, err_q;

    logic               cfg_ok, is_v, shifting, dwell_end, unit_done;
    logic [SW-1:0]      lim;
    logic [DWELL_W-1:0] dmax;

    function automatic logic [DIM_W-1:0] min_dim(
        input logic [DIM_W-1:0] a,
        input logic [DIM_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    assign cfg_ok = (width != '0) && (height != '0)
        && (hbin != '0) && (vbin != '0)
        && (num_vertical_phases >= NVW'(2))
        && (num_vertical_phases <= NVW'(VP_MAX))
        && (num_horizontal_phases >= NHW'(2))
        && (num_horizontal_phases <= NHW'(HP_MAX));

    // One step/dwell pair serves both buses; only one shift is ever active.
    assign is_v      = (state_q == FLUSH_V) || (state_q == VSHIFT);
    assign shifting  = state_q inside {FLUSH_V, FLUSH_H, VSHIFT, HSHIFT};
    assign lim       = is_v ? SW'(nv_q - NVW'(1)) : SW'(nh_q - NHW'(1));
    assign dmax      = is_v ? dv_q : dh_q;
    assign dwell_end = (dwell_q == dmax - DWELL_W'(1));
    assign unit_done = shifting && dwell_end && (step_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            hb_q    <= '0;
            vb_q    <= '0;
            nv_q    <= '0;
            nh_q    <= '0;
            dv_q    <= DWELL_W'(1);
            dh_q    <= DWELL_W'(1);
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            px_q    <= '0;
            bin_q   <= '0;
            vph_q   <= VP_MAX'(1);
            hph_q   <= HP_MAX'(1);
            rs_q    <= 1'b0;
            rc_q    <= 1'b0;
            busy_q  <= 1'b0;
            exp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            hb_q    <= hb_d;
            vb_q    <= vb_d;
            nv_q    <= nv_d;
            nh_q    <= nh_d;
            dv_q    <= dv_d;
            dh_q    <= dh_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            px_q    <= px_d;
            bin_q   <= bin_d;
            vph_q   <= vph_d;
            hph_q   <= hph_d;
            rs_q    <= rs_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        hb_d    = hb_q;
        vb_d    = vb_q;
        nv_d    = nv_q;
        nh_d    = nh_q;
        dv_d    = dv_q;
        dh_d    = dh_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        px_d    = px_q;
        bin_d   = bin_q;
        err_d   = 1'b0;

        // Step 0 wraps to 1, so consecutive units need no reload.
        if (shifting) begin
            if (dwell_end) begin
                dwell_d = '0;
                step_d  = (step_q == lim) ? '0 : step_q + SW'(1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (start_exposure && !cfg_ok) begin
                    err_d = 1'b1;
                end else if (start_exposure) begin
                    w_d     = width;
                    h_d     = height;
                    hb_d    = hbin;
                    vb_d    = vbin;
                    nv_d    = num_vertical_phases;
                    nh_d    = num_horizontal_phases;
                    dv_d    = (v_dwell == '0) ? DWELL_W'(1) : v_dwell;
                    dh_d    = (h_dwell == '0) ? DWELL_W'(1) : h_dwell;
                    step_d  = SW'(1);
                    dwell_d = '0;
                    cnt_d   = height;
                    state_d = flush_en ? FLUSH_V : EXPOSE;
                end
            end
            FLUSH_V: begin
                if (unit_done) begin
                    if (cnt_q == DIM_W'(1)) begin
                        state_d = FLUSH_H;
                        cnt_d   = w_q;
                    end else begin
                        cnt_d = cnt_q - DIM_W'(1);
                    end
                end
            end
            FLUSH_H: begin
                if (unit_done) begin
                    if (cnt_q == DIM_W'(1)) state_d = EXPOSE;
                    cnt_d = cnt_q - DIM_W'(1);
                end
            end
            EXPOSE: begin
                if (complete_exposure) state_d = READY;
            end
            READY: begin
                if (start_read) begin
                    state_d = VSHIFT;
                    cnt_d   = h_q;
                    bin_d   = min_dim(vb_q, h_q);
                    step_d  = SW'(1);
                    dwell_d = '0;
                end
            end
            VSHIFT: begin
                if (unit_done) begin
                    cnt_d = cnt_q - DIM_W'(1);
                    bin_d = bin_q - DIM_W'(1);
                    if (bin_q == DIM_W'(1)) begin
                        state_d = HSHIFT;
                        px_d    = w_q;
                        bin_d   = min_dim(hb_q, w_q);
                    end
                end
            end
            HSHIFT: begin
                if (unit_done) begin
                    px_d  = px_q - DIM_W'(1);
                    bin_d = bin_q - DIM_W'(1);
                    if (bin_q == DIM_W'(1)) state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                step_d  = SW'(1);
                dwell_d = '0;
                if (px_q != '0) begin
                    state_d = HSHIFT;
                    bin_d   = min_dim(hb_q, px_q);
                end else if (cnt_q != '0) begin
                    state_d = VSHIFT;
                    bin_d   = min_dim(vb_q, cnt_q);
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            step_d  = '0;
            dwell_d = '0;
            cnt_d   = '0;
            px_d    = '0;
            bin_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        vph_d  = VP_MAX'(1);
        hph_d  = HP_MAX'(1);
        if ((state_d == FLUSH_V) || (state_d == VSHIFT))
            vph_d = VP_MAX'(1) << step_d;
        if ((state_d == FLUSH_H) || (state_d == HSHIFT))
            hph_d = HP_MAX'(1) << step_d;
        rs_d   = (state_d == SAMPLE);
        rc_d   = (state_d == DONE);
        busy_d = (state_d != IDLE);
        exp_d  = (state_d == EXPOSE);
    end

    assign vertical_phases   = vph_q;
    assign horizontal_phases = hph_q;
    assign read_sample       = rs_q;
    assign read_completed    = rc_q;
    assign busy              = busy_q;
    assign exposing          = exp_q;
    assign cfg_error         = err_q;
endmodule
